// File: rtl/nbit_adder_pkg.sv
// Shared constants for the parallel adder datapath block.
package nbit_adder_pkg;

    localparam int ADDER_DEFAULT_WIDTH = 4;

endpackage : nbit_adder_pkg

// File: rtl/full_adder.sv
// Single-bit full adder cell; the top level chains N of these into a ripple-carry adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);

endmodule : full_adder

// File: rtl/nbit_parallel_adder.sv
// Registered N-bit ripple-carry adder exposing the full per-bit carry chain.
module nbit_parallel_adder
    import nbit_adder_pkg::*;
#(
    parameter int N = ADDER_DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         ic,
    output logic [N-1:0] out,
    output logic [N-1:0] oc,
    output logic         out_valid
);

    // chain[i] is the carry into bit i; chain[0] is the external carry-in.
    logic [N:0]   chain;
    logic [N-1:0] sum;

    assign chain[0] = ic;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a    (in1[i]),
            .b    (in2[i]),
            .cin  (chain[i]),
            .s    (sum[i]),
            .cout (chain[i+1])
        );
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values;
    // blocking here would let later statements see this cycle's updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            oc        <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Capture only on valid cycles so garbage on idle inputs never reaches the outputs.
            if (in_valid) begin
                out <= sum;
                oc  <= chain[N:1];
            end
        end
    end

endmodule : nbit_parallel_adder

// File: tb/tb_nbit_parallel_adder.sv
// Self-checking bench: directed cases, exhaustive sweep and random traffic against an arithmetic model.
module tb_nbit_parallel_adder;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         ic;
    logic [N-1:0] out;
    logic [N-1:0] oc;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] exp_out = '0;
    logic [N-1:0] exp_oc  = '0;
    logic         exp_v   = 1'b0;

    nbit_parallel_adder #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .ic        (ic),
        .out       (out),
        .oc        (oc),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Carry out of bit i is bit i+1 of the sum of the low i+1 bits of each operand plus ic.
    function automatic logic [N-1:0] model_oc(input int unsigned a, input int unsigned b,
                                               input int unsigned c);
        logic [N-1:0] r;
        int unsigned  mask;
        int unsigned  partial;
        r = '0;
        for (int i = 0; i < N; i++) begin
            mask    = (32'd1 << (i + 1)) - 1;
            partial = (a & mask) + (b & mask) + c;
            r[i]    = partial[i+1];
        end
        return r;
    endfunction

    function automatic logic [N-1:0] model_sum(input int unsigned a, input int unsigned b,
                                               input int unsigned c);
        int unsigned total;
        total = a + b + c;
        return total[N-1:0];
    endfunction

    // Apply one cycle of inputs, advance past the edge, and update the reference model.
    task automatic step(input logic r, input logic v, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic c);
        rst_n = r; in_valid = v; in1 = a; in2 = b; ic = c;
        @(posedge clk);
        #1;
        if (!r) begin
            exp_out = '0; exp_oc = '0; exp_v = 1'b0;
        end else if (v) begin
            exp_out = model_sum(a, b, c);
            exp_oc  = model_oc(a, b, c);
            exp_v   = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, N'($urandom), N'($urandom), 1'($urandom));
            checks++;
            if ({out_valid, oc, out} !== {1'b0, 4'b0000, 4'b0000}) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got v=%b oc=%b out=%b want 0/0000/0000",
                         i, out_valid, oc, out);
            end
        end
        step(1'b1, 1'b0, N'($urandom), N'($urandom), 1'($urandom));
        checks++;
        if ({out_valid, oc, out} !== {1'b0, 4'b0000, 4'b0000}) begin
            errors++;
            $display("FAIL reset_release got v=%b oc=%b out=%b want 0/0000/0000",
                     out_valid, oc, out);
        end
    endtask

    task automatic test_directed();
        logic [N-1:0] ta [6] = '{4'b0010, 4'b1111, 4'b1111, 4'b0111, 4'b0101, 4'b0101};
        logic [N-1:0] tb [6] = '{4'b0001, 4'b0001, 4'b0000, 4'b0111, 4'b1010, 4'b1010};
        logic         tc [6] = '{1'b0,    1'b0,    1'b1,    1'b0,    1'b0,    1'b1};
        logic [N-1:0] eo [6] = '{4'b0011, 4'b0000, 4'b0000, 4'b1110, 4'b1111, 4'b0000};
        logic [N-1:0] ec [6] = '{4'b0000, 4'b1111, 4'b1111, 4'b0111, 4'b0000, 4'b1111};
        // All six cases are issued back to back, so every result cycle must show out_valid=1.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, ta[i], tb[i], tc[i]);
            checks++;
            if ({out_valid, oc, out} !== {1'b1, ec[i], eo[i]}) begin
                errors++;
                $display("FAIL directed_%0d got v=%b oc=%b out=%b want 1/%b/%b",
                         i, out_valid, oc, out, ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [N-1:0] keep_out;
        logic [N-1:0] keep_oc;
        step(1'b1, 1'b1, 4'b1001, 4'b0110, 1'b1);
        keep_out = 4'b0000;
        keep_oc  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, N'($urandom), N'($urandom), 1'($urandom));
            checks++;
            if ({out_valid, oc, out} !== {1'b0, keep_oc, keep_out}) begin
                errors++;
                $display("FAIL hold_%0d got v=%b oc=%b out=%b want 0/%b/%b",
                         i, out_valid, oc, out, keep_oc, keep_out);
            end
        end
    endtask

    task automatic test_midstream_reset();
        step(1'b1, 1'b1, 4'b1100, 4'b0111, 1'b0);
        step(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1);
        checks++;
        if ({out_valid, oc, out} !== {1'b0, 4'b0000, 4'b0000}) begin
            errors++;
            $display("FAIL midstream_reset got v=%b oc=%b out=%b want 0/0000/0000",
                     out_valid, oc, out);
        end
    endtask

    task automatic test_exhaustive();
        int unsigned total;
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    step(1'b1, 1'b1, N'(a), N'(b), 1'(c));
                    total = a + b + c;
                    checks++;
                    if ({out_valid, oc[N-1], out} !== {1'b1, 5'(total)} ||
                        oc !== exp_oc) begin
                        errors++;
                        $display("FAIL exhaustive a=%0d b=%0d c=%0d got v=%b oc=%b out=%b want 1/%b/%b",
                                 a, b, c, out_valid, oc, out, exp_oc, 4'(total));
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) != 0), 1'($urandom), N'($urandom), N'($urandom),
                 1'($urandom));
            checks++;
            if ({out_valid, oc, out} !== {exp_v, exp_oc, exp_out}) begin
                errors++;
                $display("FAIL random_%0d got v=%b oc=%b out=%b want %b/%b/%b",
                         i, out_valid, oc, out, exp_v, exp_oc, exp_out);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; ic = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_hold();
        test_midstream_reset();
        test_exhaustive();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_nbit_parallel_adder

// File: doc/nbit_parallel_adder.md
Name: nbit_parallel_adder

Overview:
- Registered N-bit ripple-carry (parallel) adder: sums two N-bit operands plus a carry-in.
- Outputs the N-bit sum and the full per-bit carry chain; the MSB of the carry chain is the adder carry-out.
- Sits as a leaf arithmetic block in the datapath. Default width is 4 bits.

Parameters:
- N, 4, operand/sum/carry-chain width in bits; legal range 1..64.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operands and carry-in are valid this cycle; capture enable.
- in1  input  N  operand A, unsigned.
- in2  input  N  operand B, unsigned.
- ic  input  1  carry-in to bit 0.
- out  output  N  registered sum bits.
- oc  output  N  registered per-bit carry-outs; oc[i] = carry out of bit i; oc[N-1] = final carry-out.
- out_valid  output  1  out/oc hold a result produced from an in_valid cycle.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Combinational core is a ripple chain of N full adders:
  - c[-1] = ic
  - s[i] = in1[i] ^ in2[i] ^ c[i-1]
  - c[i] = (in1[i] & in2[i]) | (c[i-1] & (in1[i] ^ in2[i]))
- Arithmetic identity: {oc[N-1], out} == in1 + in2 + ic, computed at N+1 bits. No overflow flag; unsigned only.
- Latency: exactly 1 cycle. A rising edge with rst_n=1 and in_valid=1 registers out <= s and oc <= c, and sets out_valid <= 1.
- Rising edge with rst_n=1 and in_valid=0: out and oc hold their previous values; out_valid <= 0.
- Reset: any rising edge with rst_n=0 forces out=0, oc=0, out_valid=0. Reset has priority over in_valid. Reset mid-stream discards any in-flight result.
- No backpressure: a result is presented for one cycle with out_valid=1. Back-to-back in_valid cycles produce back-to-back results.
- Inputs are don't-care when in_valid=0. X on inputs while in_valid=0 must not propagate to out/oc.
- No internal state other than the output registers.

Decomposition:
- Shared package nbit_adder_pkg holds the constant ADDER_DEFAULT_WIDTH = 4.
- Natural sub-module: full_adder (a, b, cin -> s, cout), instantiated N times by a generate loop and chained cin <- previous cout.
- The top level adds only the output register stage and out_valid.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs and in_valid=1 -> out=0000, oc=0000, out_valid=0. Release reset -> values stay 0 until the first valid capture.
- Basic add: in1=0010, in2=0001, ic=0, in_valid=1 -> next cycle out=0011 (3), oc=0000, out_valid=1.
- Full carry ripple: in1=1111, in2=0001, ic=0 -> out=0000, oc=1111. Also in1=1111, in2=0000, ic=1 -> out=0000, oc=1111.
- Partial chain: in1=0111, in2=0111, ic=0 -> out=1110, oc=0111.
- Carry-in effect, same operands: in1=0101, in2=1010. With ic=0 -> out=1111, oc=0000. With ic=1 -> out=0000, oc=1111. Drive both on back-to-back cycles -> out_valid=1 on both result cycles.
- Hold and exhaustive:
  - Drop in_valid after a result -> out/oc unchanged, out_valid=0.
  - Sweep all 512 (in1, in2, ic) combinations at N=4 -> {oc[3], out} == in1+in2+ic every cycle.
